// File: rtl/pio_poll_pkg.sv
// pio_poll_pkg: shared state codes, bus constants and parameter defaults
// for the PIO ready-flag polling master.
package pio_poll_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WRITE   = 3'd1;
  localparam state_t S_RD_REQ  = 3'd2;
  localparam state_t S_RD_WAIT = 3'd3;
  localparam state_t S_GAP     = 3'd4;
  localparam state_t S_DONE    = 3'd5;
  localparam state_t S_TIMEOUT = 3'd6;

  localparam logic [3:0] BE_ALL = 4'hF;

  localparam int P_ADDR_W    = 32;
  localparam int P_READY_BIT = 0;
  localparam int P_POLL_GAP  = 16;
  localparam int P_MAX_POLLS = 1024;
  localparam int P_CNT_W     = 16;

endpackage

// File: rtl/pio_ready_poll_master_if.sv
// pio_ready_poll_master_if: Avalon-MM master/slave signal bundle
// for the PIO ready-flag polling master.
interface pio_ready_poll_master_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/avm_single_xfer.sv
// avm_single_xfer: drives one Avalon-MM read or write at a time and
// reports acceptance, completion and the captured readdata.
module avm_single_xfer
  import pio_poll_pkg::*;
#(
  parameter int ADDR_W    = P_ADDR_W,
  parameter int READY_BIT = P_READY_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_req,
  input  logic              i_rd_req,
  input  logic              i_rd_wait,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_req_ack,
  output logic              o_xfer_done,
  output logic              o_ready,
  output logic [31:0]       o_rdata,
  pio_ready_poll_master_if.master avm
);

  logic        w_rd_valid;
  logic [31:0] r_rdata;

  // readdatavalid only counts while a read is actually outstanding
  assign w_rd_valid  = i_rd_wait & avm.avm_readdatavalid;
  assign o_req_ack   = (i_wr_req | i_rd_req) & ~avm.avm_waitrequest;
  assign o_xfer_done = (i_wr_req & ~avm.avm_waitrequest) | w_rd_valid;
  assign o_ready     = avm.avm_readdata[READY_BIT];
  assign o_rdata     = r_rdata;

  always_comb begin
    avm.avm_write      = i_wr_req;
    avm.avm_read       = i_rd_req & ~i_wr_req;
    avm.avm_address    = '0;
    avm.avm_writedata  = '0;
    avm.avm_byteenable = BE_ALL;
    if (i_wr_req) begin
      avm.avm_address   = i_wr_addr;
      avm.avm_writedata = i_wr_data;
    end else if (i_rd_req) begin
      avm.avm_address = i_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_rd_valid) begin
      r_rdata <= avm.avm_readdata;
    end
  end

endmodule

// File: rtl/pio_ready_poll_master.sv
// pio_ready_poll_master: writes one command, then polls a status PIO
// until its ready bit is set or the poll budget is exhausted.
module pio_ready_poll_master
  import pio_poll_pkg::*;
#(
  parameter int ADDR_W    = P_ADDR_W,
  parameter int READY_BIT = P_READY_BIT,
  parameter int POLL_GAP  = P_POLL_GAP,
  parameter int MAX_POLLS = P_MAX_POLLS,
  parameter int CNT_W     = P_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic [ADDR_W-1:0] poll_addr,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       status,
  output logic [CNT_W-1:0]  poll_count,
  pio_ready_poll_master_if.master avm
);

  localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_POLLS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [31:0]       r_cmd_data;
  logic [ADDR_W-1:0] r_poll_addr;
  logic [CNT_W-1:0]  r_poll_cnt;
  logic [CNT_W-1:0]  r_gap_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_req_ack;
  logic              w_xfer_done;
  logic              w_ready;

  assign w_cnt_nxt  = r_poll_cnt + ONE;
  assign poll_count = r_poll_cnt;
  assign done       = (r_state == S_DONE);
  assign timeout    = (r_state == S_TIMEOUT);
  assign busy       = (r_state == S_WRITE) || (r_state == S_RD_REQ) ||
                      (r_state == S_RD_WAIT) || (r_state == S_GAP);

  avm_single_xfer #(
    .ADDR_W    (ADDR_W),
    .READY_BIT (READY_BIT)
  ) u_xfer (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_wr_req    (r_state == S_WRITE),
    .i_rd_req    (r_state == S_RD_REQ),
    .i_rd_wait   (r_state == S_RD_WAIT),
    .i_wr_addr   (r_cmd_addr),
    .i_wr_data   (r_cmd_data),
    .i_rd_addr   (r_poll_addr),
    .o_req_ack   (w_req_ack),
    .o_xfer_done (w_xfer_done),
    .o_ready     (w_ready),
    .o_rdata     (status),
    .avm         (avm)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_poll_addr <= '0;
      r_poll_cnt  <= '0;
      r_gap_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cmd_addr  <= cmd_addr;
            r_cmd_data  <= cmd_data;
            r_poll_addr <= poll_addr;
            r_poll_cnt  <= '0;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_xfer_done) r_state <= S_RD_REQ;
        end
        S_RD_REQ: begin
          if (w_req_ack) r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (w_xfer_done) begin
            r_poll_cnt <= w_cnt_nxt;
            // ready wins over an exhausted budget on the same read
            if (w_ready) begin
              r_state <= S_DONE;
            end else if (w_cnt_nxt == MAXP) begin
              r_state <= S_TIMEOUT;
            end else if (POLL_GAP == 0) begin
              r_state <= S_RD_REQ;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_RD_REQ;
          end else begin
            r_gap_cnt <= r_gap_cnt + ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
